// File: rtl/ball_motion.sv
// Ball physics stepper for a tilt-controlled labyrinth board.
// Each physics tick runs a fixed three-cycle sequence. First the tilt is
// latched, then the velocity is integrated and saturated, and finally the
// Q10.6 position is integrated and clamped against the walls with a damped
// bounce.

module ball_motion #(
    parameter int BOARD_W = 640,
    parameter int BOARD_H = 480,
    parameter int BALL_R  = 8,
    parameter int SHIFT   = 4,
    parameter int VMAX    = 511
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] sin_x,
    input  logic [10:0] sin_y,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [11:0] vel_x,
    output logic [11:0] vel_y,
    output logic        hit_x,
    output logic        hit_y,
    output logic        running,
    output logic        overrun
);

    // Centre position and wall limits, all in Q10.6 (1/64 px) units
    localparam logic [15:0]        CENTRE_X = 16'(BOARD_W / 2 * 64);
    localparam logic [15:0]        CENTRE_Y = 16'(BOARD_H / 2 * 64);
    localparam logic signed [16:0] LO_X     = 17'(BALL_R * 64);
    localparam logic signed [16:0] HI_X     = 17'((BOARD_W - 1 - BALL_R) * 64);
    localparam logic signed [16:0] LO_Y     = 17'(BALL_R * 64);
    localparam logic signed [16:0] HI_Y     = 17'((BOARD_H - 1 - BALL_R) * 64);
    localparam logic signed [12:0] VLIM     = 13'(VMAX);
    localparam logic signed [12:0] VLIM_N   = -VLIM;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_VEL  = 2'd2,
        S_POS  = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] p;
        logic [11:0] v;
        logic        hit;
    } axis_t;

    // Velocity integration: add the floored tilt acceleration, then saturate.
    // The 13-bit sum cannot wrap because |v| <= VMAX and |acc| <= 64.
    function automatic logic signed [11:0] vel_step(input logic signed [11:0] v,
                                                    input logic signed [10:0] s);
        logic signed [10:0] acc;
        logic signed [12:0] sum;
        logic signed [11:0] r;
        acc = s >>> SHIFT;
        sum = $signed({v[11], v}) + $signed({{2{acc[10]}}, acc});
        if (sum > VLIM) begin
            r = VLIM[11:0];
        end else if (sum < VLIM_N) begin
            r = VLIM_N[11:0];
        end else begin
            r = sum[11:0];
        end
        return r;
    endfunction

    // Position integration with wall clamp; landing exactly on a limit is
    // not a collision. A clamp reverses and halves (floored) the velocity.
    function automatic axis_t axis_step(input logic [15:0]        p,
                                        input logic signed [11:0] v,
                                        input logic signed [16:0] lo,
                                        input logic signed [16:0] hi);
        axis_t              r;
        logic signed [16:0] p_next;
        logic signed [11:0] half;
        p_next = $signed({1'b0, p}) + $signed({{5{v[11]}}, v});
        half   = v >>> 1;
        if (p_next < lo) begin
            r.p   = lo[15:0];
            r.v   = -half;
            r.hit = 1'b1;
        end else if (p_next > hi) begin
            r.p   = hi[15:0];
            r.v   = -half;
            r.hit = 1'b1;
        end else begin
            r.p   = p_next[15:0];
            r.v   = v;
            r.hit = 1'b0;
        end
        return r;
    endfunction

    state_t             state;
    state_t             state_next;
    logic               do_load;
    logic               do_vel;
    logic               do_pos;
    logic               drop;
    logic signed [10:0] sin_x_r;
    logic signed [10:0] sin_y_r;
    logic [15:0]        pos_x_r;
    logic [15:0]        pos_y_r;
    logic signed [11:0] vel_x_r;
    logic signed [11:0] vel_y_r;
    logic               hit_x_r;
    logic               hit_y_r;
    logic               overrun_r;
    logic signed [11:0] vel_x_sat;
    logic signed [11:0] vel_y_sat;
    axis_t              step_x;
    axis_t              step_y;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stop beats start, start beats the step sequence
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = S_IDLE;
        end else if (start) begin
            state_next = S_WAIT;
        end else begin
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_WAIT:  state_next = tick ? S_VEL : S_WAIT;
                S_VEL:   state_next = S_POS;
                S_POS:   state_next = S_WAIT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output/control decode: step strobes are suppressed by start or stop
    always_comb begin
        running = 1'b0;
        do_load = 1'b0;
        do_vel  = 1'b0;
        do_pos  = 1'b0;
        drop    = 1'b0;
        if (state != S_IDLE) begin
            running = 1'b1;
        end else begin
            running = 1'b0;
        end
        if (!stop && !start) begin
            do_load = (state == S_WAIT) && tick;
            do_vel  = (state == S_VEL);
            do_pos  = (state == S_POS);
            drop    = ((state == S_VEL) || (state == S_POS)) && tick;
        end else begin
            do_load = 1'b0;
            do_vel  = 1'b0;
            do_pos  = 1'b0;
            drop    = 1'b0;
        end
    end

    // Combinational physics for both axes
    always_comb begin
        vel_x_sat = vel_step(vel_x_r, sin_x_r);
        vel_y_sat = vel_step(vel_y_r, sin_y_r);
        step_x    = axis_step(pos_x_r, vel_x_r, LO_X, HI_X);
        step_y    = axis_step(pos_y_r, vel_y_r, LO_Y, HI_Y);
    end

    // Tilt snapshot taken as the step starts, so later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_x_r <= 11'sd0;
            sin_y_r <= 11'sd0;
        end else if (do_load) begin
            sin_x_r <= $signed(sin_x);
            sin_y_r <= $signed(sin_y);
        end else begin
            sin_x_r <= sin_x_r;
            sin_y_r <= sin_y_r;
        end
    end

    // Motion state: position, velocity, collision pulses and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_r   <= CENTRE_X;
            pos_y_r   <= CENTRE_Y;
            vel_x_r   <= 12'sd0;
            vel_y_r   <= 12'sd0;
            hit_x_r   <= 1'b0;
            hit_y_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            hit_x_r <= 1'b0;
            hit_y_r <= 1'b0;
            if (!stop && start) begin
                pos_x_r   <= CENTRE_X;
                pos_y_r   <= CENTRE_Y;
                vel_x_r   <= 12'sd0;
                vel_y_r   <= 12'sd0;
                overrun_r <= 1'b0;
            end else begin
                if (do_vel) begin
                    vel_x_r <= vel_x_sat;
                    vel_y_r <= vel_y_sat;
                end else if (do_pos) begin
                    pos_x_r <= step_x.p;
                    pos_y_r <= step_y.p;
                    vel_x_r <= $signed(step_x.v);
                    vel_y_r <= $signed(step_y.v);
                    hit_x_r <= step_x.hit;
                    hit_y_r <= step_y.hit;
                end else begin
                    pos_x_r <= pos_x_r;
                    pos_y_r <= pos_y_r;
                    vel_x_r <= vel_x_r;
                    vel_y_r <= vel_y_r;
                end
                if (drop) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r <= overrun_r;
                end
            end
        end
    end

    assign pos_x   = pos_x_r[15:6];
    assign pos_y   = pos_y_r[15:6];
    assign vel_x   = vel_x_r;
    assign vel_y   = vel_y_r;
    assign hit_x   = hit_x_r;
    assign hit_y   = hit_y_r;
    assign overrun = overrun_r;

endmodule
